bitvec_index_encoder: RTL and testbench

BITVEC_INDEX_ENCODER -- requirements
Module: bitvec_index_encoder

---
 rtl/bitvec_index_encoder.sv | 152 +++++++++++++++
 tb/tb_bitvec_index_encoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitvec_index_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : bitvec_index_encoder
//  Purpose  : Accepts a 32-bit multi-hot vector and emits the index of every
//             set bit as a stream of valid/ready beats, one index per cycle.
//             The indices come out in ascending order (LOW_FIRST = 1) or in
//             descending order (LOW_FIRST = 0). The final index of a vector
//             is flagged with out_last. An all-zero vector is accepted,
//             dropped, and reported with a one-cycle zero_drop pulse.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   single clock; all state updates on the rising edge
//    rst_n      in   1   synchronous active-low reset
//    in_valid   in   1   in_vec is offered
//    in_ready   out  1   block accepts in_vec this cycle (IDLE, not in reset)
//    in_vec     in   32  multi-hot vector; bit i set = index i pending
//    out_valid  out  1   out_idx is valid (high throughout SCAN)
//    out_ready  in   1   consumer takes out_idx this cycle
//    out_idx    out  5   binary index of the selected set bit (0 when idle)
//    out_last   out  1   current beat is the final index of the vector
//    zero_drop  out  1   one-cycle pulse: all-zero vector accepted, discarded
// ============================================================================
module bitvec_index_encoder #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_vec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic        out_last,
  output logic        zero_drop
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic [31:0] pending_q;
  logic [31:0] pending_d;
  logic        zero_drop_q;
  logic        zero_drop_d;

  logic [4:0]  sel_idx;
  logic        single_bit;
  logic        accept;
  logic        take;

  // --------------------------------------------------------------------------
  // Index selection. The loop direction decides which set bit wins: the last
  // assignment in the loop takes priority, so scanning from the top down
  // leaves the lowest set index and scanning from the bottom up leaves the
  // highest.
  // --------------------------------------------------------------------------
  generate
    if (LOW_FIRST) begin : g_low_first
      always_comb begin
        sel_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
          if (pending_q[i]) begin
            sel_idx = 5'(i);
          end
        end
      end
    end else begin : g_high_first
      always_comb begin
        sel_idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
          if (pending_q[i]) begin
            sel_idx = 5'(i);
          end
        end
      end
    end
  endgenerate

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign single_bit = (pending_q != 32'd0) &&
                      ((pending_q & (pending_q - 32'd1)) == 32'd0);

  // --------------------------------------------------------------------------
  // Handshake and output decode
  // --------------------------------------------------------------------------
  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_SCAN);
  assign out_idx   = out_valid ? sel_idx : 5'd0;
  assign out_last  = out_valid && single_bit;
  assign zero_drop = zero_drop_q;

  assign accept = in_valid && in_ready;
  assign take   = out_valid && out_ready;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    zero_drop_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_vec != 32'd0) begin
            pending_d = in_vec;
            state_d   = ST_SCAN;
          end else begin
            zero_drop_d = 1'b1;
          end
        end
      end

      ST_SCAN: begin
        // in_valid/in_vec are ignored here: in_ready is low, so no accept.
        if (take) begin
          pending_d = pending_q & ~(32'd1 << sel_idx);
          if (single_bit) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= 32'd0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      zero_drop_q <= zero_drop_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitvec_index_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitvec_index_encoder
//  Purpose  : Self-checking bench for bitvec_index_encoder. Two instances run
//             side by side on identical stimulus, one ascending and one
//             descending. A queue-based model predicts the index streams.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitvec_index_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_vec;
  logic        out_ready;

  logic        lo_in_ready, lo_out_valid, lo_out_last, lo_zero_drop;
  logic [4:0]  lo_out_idx;
  logic        hi_in_ready, hi_out_valid, hi_out_last, hi_zero_drop;
  logic [4:0]  hi_out_idx;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  bitvec_index_encoder #(.LOW_FIRST(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(lo_in_ready),
    .in_vec(in_vec), .out_valid(lo_out_valid), .out_ready(out_ready),
    .out_idx(lo_out_idx), .out_last(lo_out_last), .zero_drop(lo_zero_drop)
  );

  bitvec_index_encoder #(.LOW_FIRST(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(hi_in_ready),
    .in_vec(in_vec), .out_valid(hi_out_valid), .out_ready(out_ready),
    .out_idx(hi_out_idx), .out_last(hi_out_last), .zero_drop(hi_zero_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: on accept, the set-bit indices of the vector are listed
  // in emission order; each handshake pops the head.
  // --------------------------------------------------------------------------
  int q_lo[$];
  int q_hi[$];
  bit m_zd = 1'b0;
  int dummy;

  always @(posedge clk) begin
    if (!rst_n) begin
      q_lo.delete();
      q_hi.delete();
      m_zd = 1'b0;
    end else begin
      m_zd = 1'b0;
      if (q_lo.size() != 0) begin
        if (out_ready) begin
          dummy = q_lo.pop_front();
          dummy = q_hi.pop_front();
        end
      end else if (in_valid) begin
        if (in_vec == 32'd0) begin
          m_zd = 1'b1;
        end else begin
          for (int i = 0; i < 32; i++) begin
            if (in_vec[i]) begin
              q_lo.push_back(i);
              q_hi.push_front(i);
            end
          end
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  bit e_rdy, e_v, e_last;
  int e_lo, e_hi;
  always @(negedge clk) begin
    if (mon_en) begin
      e_rdy  = rst_n && (q_lo.size() == 0);
      e_v    = (q_lo.size() != 0);
      e_lo   = e_v ? q_lo[0] : 0;
      e_hi   = e_v ? q_hi[0] : 0;
      e_last = (q_lo.size() == 1);
      chk("lo.in_ready",  32'(lo_in_ready),  32'(e_rdy));
      chk("lo.out_valid", 32'(lo_out_valid), 32'(e_v));
      chk("lo.out_idx",   32'(lo_out_idx),   32'(e_lo));
      chk("lo.out_last",  32'(lo_out_last),  32'(e_last));
      chk("lo.zero_drop", 32'(lo_zero_drop), 32'(m_zd));
      chk("hi.in_ready",  32'(hi_in_ready),  32'(e_rdy));
      chk("hi.out_valid", 32'(hi_out_valid), 32'(e_v));
      chk("hi.out_idx",   32'(hi_out_idx),   32'(e_hi));
      chk("hi.out_last",  32'(hi_out_last),  32'(e_last));
      chk("hi.zero_drop", 32'(hi_zero_drop), 32'(m_zd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string name, input int lo, input int hi, input bit last);
    chk({name, ".valid"}, 32'(lo_out_valid), 32'd1);
    chk({name, ".lo_idx"}, 32'(lo_out_idx), 32'(lo));
    chk({name, ".hi_idx"}, 32'(hi_out_idx), 32'(hi));
    chk({name, ".lo_last"}, 32'(lo_out_last), 32'(last));
    chk({name, ".hi_last"}, 32'(hi_out_last), 32'(last));
  endtask

  function automatic logic [31:0] rand_vec();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0:       v = 32'd0;
      1:       v = 32'd1 << $urandom_range(0, 31);
      2:       v = $urandom & $urandom & $urandom;
      3:       v = $urandom;
      default: v = ~(32'd1 << $urandom_range(0, 31));
    endcase
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_vec = 32'd0; out_ready = 1'b0;
    tick();
    mon_en = 1'b1;
    #1;
    chk("rst.in_ready",  32'(lo_in_ready),  32'd0);
    chk("rst.out_valid", 32'(lo_out_valid), 32'd0);
    chk("rst.out_idx",   32'(lo_out_idx),   32'd0);
    chk("rst.out_last",  32'(lo_out_last),  32'd0);
    chk("rst.zero_drop", 32'(lo_zero_drop), 32'd0);

    // Single bit 0
    tick();
    rst_n = 1'b1; in_valid = 1'b1; in_vec = 32'h0000_0001; out_ready = 1'b1;
    #1 chk("one.in_ready", 32'(lo_in_ready), 32'd1);
    tick(); in_valid = 1'b0; #1;
    beat("one", 0, 0, 1'b1);
    chk("one.busy_rdy", 32'(lo_in_ready), 32'd0);
    tick(); #1;
    chk("one.done_valid", 32'(lo_out_valid), 32'd0);
    chk("one.done_rdy", 32'(lo_in_ready), 32'd1);

    // Three bits, ordering in both directions
    in_valid = 1'b1; in_vec = 32'h8000_0011;
    tick(); in_valid = 1'b0; #1 beat("tri0", 0, 31, 1'b0);
    tick(); #1 beat("tri1", 4, 4, 1'b0);
    tick(); #1 beat("tri2", 31, 0, 1'b1);
    tick(); #1 chk("tri.done_valid", 32'(lo_out_valid), 32'd0);

    // Back-pressure holds the current beat
    in_valid = 1'b1; in_vec = 32'h0000_0006; out_ready = 1'b0;
    tick(); in_valid = 1'b0; #1 beat("bp.a", 1, 2, 1'b0);
    tick(); #1 beat("bp.b", 1, 2, 1'b0);
    tick(); #1 beat("bp.c", 1, 2, 1'b0);
    tick(); out_ready = 1'b1; #1 beat("bp.d", 1, 2, 1'b0);
    tick(); #1 beat("bp.e", 2, 1, 1'b1);
    tick(); #1 chk("bp.done_valid", 32'(lo_out_valid), 32'd0);

    // All-zero vector is dropped
    in_valid = 1'b1; in_vec = 32'd0;
    #1 chk("zero.pre", 32'(lo_zero_drop), 32'd0);
    tick(); in_valid = 1'b0; #1;
    chk("zero.pulse", 32'(lo_zero_drop), 32'd1);
    chk("zero.valid", 32'(lo_out_valid), 32'd0);
    chk("zero.rdy",   32'(lo_in_ready),  32'd1);
    tick(); #1 chk("zero.after", 32'(lo_zero_drop), 32'd0);

    // Full vector, with input activity ignored during the scan
    in_valid = 1'b1; in_vec = 32'hFFFF_FFFF;
    tick();
    for (int k = 0; k < 32; k++) begin
      in_valid = k[0];
      in_vec   = $urandom;
      #1 beat("full", k, 31 - k, k == 31);
      chk("full.rdy", 32'(lo_in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    #1 chk("full.done_valid", 32'(lo_out_valid), 32'd0);
    chk("full.done_rdy", 32'(lo_in_ready), 32'd1);

    // Reset mid-scan
    in_valid = 1'b1; in_vec = 32'h0000_F000;
    tick(); in_valid = 1'b0; #1 beat("mid0", 12, 15, 1'b0);
    tick(); #1 beat("mid1", 13, 14, 1'b0);
    tick(); rst_n = 1'b0; #1 chk("mid.rst_rdy", 32'(lo_in_ready), 32'd0);
    tick(); rst_n = 1'b1; #1;
    chk("mid.valid", 32'(lo_out_valid), 32'd0);
    chk("mid.idx",   32'(hi_out_idx),   32'd0);
    chk("mid.rdy",   32'(lo_in_ready),  32'd1);
    tick(); #1 chk("mid.stay_idle", 32'(hi_out_valid), 32'd0);

    // Randomized traffic against the model
    repeat (3000) begin
      tick();
      in_valid  = ($urandom_range(0, 2) != 0);
      in_vec    = rand_vec();
      out_ready = ($urandom_range(0, 9) < 7);
      rst_n     = ($urandom_range(0, 249) != 0);
    end
    tick();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
